// File: rtl/picosoc_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port SRAM with a
// one-cycle registered read. Each access walks IDLE -> ACCESS -> RESP.
module picosoc_mem_arbiter #(
  parameter int WORDS = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic [3:0]  mem_wen,
  output logic [21:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [31:0] WORDS_U = 32'(WORDS);

  state_t      state_q, state_d;
  logic        last_q, last_d;     // id of the most recently granted master
  logic        gnt_q, gnt_d;       // id of the master owning the current access
  logic [21:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        in_range;
  logic        sel;

  // Word addresses at or above the populated depth complete without effect.
  assign in_range = ({10'd0, addr_q} < WORDS_U);

  // State and request-latch registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Next-state: arbitrate in IDLE, then step through ACCESS and RESP.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    sel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          // On contention the master that did not win last time goes first.
          if (m0_valid && m1_valid) sel = ~last_q;
          else                      sel = m1_valid;
          gnt_d   = sel;
          last_d  = sel;
          addr_d  = sel ? m1_addr[23:2] : m0_addr[23:2];
          wdata_d = sel ? m1_wdata : m0_wdata;
          wstrb_d = sel ? m1_wstrb : m0_wstrb;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only from registered state, so mem_wen cannot glitch on valid.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wen   = 4'd0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = 32'd0;
    m1_rdata  = 32'd0;
    if (state_q == ACCESS && in_range) mem_wen = wstrb_q;
    if (state_q == RESP) begin
      if (gnt_q) begin
        m1_ready = 1'b1;
        m1_rdata = in_range ? mem_rdata : 32'd0;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = in_range ? mem_rdata : 32'd0;
      end
    end
  end

endmodule
